csa_multi_operand_ctrl: RTL and testbench
=========================================

Name: csa_multi_operand_ctrl

Overview:
- Sequencing controller that reduces a stream of WIDTH-bit operands into one sum.
- Each accepted operand is folded into a registered redundant pair (sum, carry) with one 3:2 carry-save step per cycle.
- After the last operand, one carry-propagate add resolves the pair.
- Sits between an operand producer and a result consumer, both using valid/ready handshakes. Time-shares a single CSA stage across an arbitrary-length operand list.

Parameters:
- WIDTH, 4, operand width in bits.
- RES_W, 8, accumulator/result width; arithmetic is modulo 2^RES_W.
- MAX_OPS, 16, maximum operands per group; reaching it forces resolution.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand valid.
- in_ready  output  1  controller can accept an operand this cycle.
- in_data  input  WIDTH  operand, unsigned, zero-extended to RES_W.
- in_last  input  1  marks the final operand of the group; qualified by in_valid.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_sum  output  RES_W  resolved sum.
- out_count  output  $clog2(MAX_OPS+1)  number of operands in the group.
- out_ovf  output  1  true sum exceeded 2^RES_W-1 (see Optional Feature).

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset (async, any state):
  - state=IDLE; sum_r, carry_r, out_sum, out_count all 0.
  - ovf_r and out_valid 0; in_ready 0 while rst_n low.
- Accept means in_valid && in_ready at a rising edge.
- in_ready = 1 in IDLE and ACCUM, else 0. out_valid = 1 only in DONE.
- CSA step (a=sum_r, b=carry_r, c=zext(in_data)):
  - s = a^b^c.
  - m = (a&b)|(a&c)|(b&c).
  - carry_next = {m[RES_W-2:0],1'b0}; m[RES_W-1] is dropped.
  - A dropped m[RES_W-1]=1 sets ovf_r (sticky within the group).
- IDLE:
  - On accept: sum_r=zext(in_data), carry_r=0, cnt=1, ovf_r=0.
  - Next state is RESOLVE if in_last or MAX_OPS==1, else ACCUM.
- ACCUM:
  - On accept: apply CSA step, cnt=cnt+1.
  - Next state is RESOLVE if in_last or cnt+1==MAX_OPS, else stay in ACCUM.
  - No accept: registers hold; no timeout.
- RESOLVE (exactly 1 cycle):
  - {co,out_sum} = sum_r + carry_r (RES_W+1 bits).
  - out_count=cnt; out_ovf = ovf_r | co.
  - Next state DONE.
- DONE:
  - Outputs held stable while out_ready=0.
  - On out_valid && out_ready: go to IDLE. A new operand can be accepted on the following cycle.
- Latency: last operand accepted at edge k -> RESOLVE during cycle k..k+1 -> out_valid high after edge k+1. Minimum group throughput is N+2 cycles for N operands.
- in_last when MAX_OPS is reached: both terminate; same result.
- in_data/in_last are ignored when in_ready=0.
- Reset mid-group discards all partial state; no result is emitted.
- out_sum always equals (true sum) mod 2^RES_W.

Optional Feature:
- Macro CSA_OVF_DETECT_EN.
- Defined: ovf_r tracking and the final carry-out are implemented; out_ovf as specified.
- Undefined: ovf_r logic is omitted and out_ovf is tied 0; all other behaviour is identical.

Test Plan:
- Operands 5,3,6 (last on 6), out_ready=1 -> out_sum=0x0E, out_count=3, out_ovf=0; out_valid high 2 edges after the last accept, for 1 cycle.
- Operands 2,12,10 (last on 10) -> out_sum=0x18, out_count=3. Single operand 9 with in_last -> out_sum=0x09, out_count=1, via IDLE->RESOLVE->DONE.
- 16 operands of 15, in_last never asserted (MAX_OPS=16) -> auto-resolve after the 16th; out_sum=240, out_count=16, out_ovf=0; in_ready low from that edge.
- RES_W=6, five operands of 15 -> out_sum=11 (75 mod 64), out_ovf=1 with CSA_OVF_DETECT_EN; out_ovf=0 without it.
- Result ready, out_ready held 0 for 3 cycles -> out_valid, out_sum, out_count stable and in_ready=0 throughout; IDLE on the 4th-cycle handshake; next group 1,1 (last) -> 2.
- rst_n pulsed low after 2 of 4 operands -> all outputs 0 immediately (async); new group 7,7 (last) -> out_sum=14, out_count=2 with no stale contribution.

Source files
------------

// File: rtl/csa_multi_operand_ctrl.sv
// Folds a valid/ready operand stream into one sum through a time-shared 3:2 CSA stage; CSA_OVF_DETECT_EN adds out_ovf.
// Result valid 2 edges after the last accept; in_ready is low from RESOLVE until the result handshakes.
module csa_multi_operand_ctrl #(
  parameter int WIDTH   = 4,
  parameter int RES_W   = 8,
  parameter int MAX_OPS = 16,
  localparam int CNT_W  = $clog2(MAX_OPS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, DONE} state_t;

  state_t           state, state_nxt;
  logic [RES_W-1:0] sum_r, carry_r;
  logic [CNT_W-1:0] cnt;
  logic [RES_W-1:0] operand, csa_s, csa_m, csa_c;
  logic             accept;
  logic             hit_max;

  assign in_ready  = rst_n && (state == IDLE || state == ACCUM);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign hit_max   = ((cnt + 1'b1) == CNT_W'(MAX_OPS));

  assign operand = RES_W'(in_data);
  assign csa_s   = sum_r ^ carry_r ^ operand;
  assign csa_m   = (sum_r & carry_r) | (sum_r & operand) | (carry_r & operand);
  // The shift discards the majority MSB; its weight 2^RES_W is only tracked as overflow.
  assign csa_c   = csa_m << 1;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (in_last || MAX_OPS == 1) ? RESOLVE : ACCUM;
      ACCUM:   if (accept) state_nxt = (in_last || hit_max) ? RESOLVE : ACCUM;
      RESOLVE: state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef CSA_OVF_DETECT_EN
  logic             ovf_r;
  logic [RES_W:0]   resolved;
  assign resolved = {1'b0, sum_r} + {1'b0, carry_r};
`else
  logic [RES_W-1:0] resolved;
  assign resolved = sum_r + carry_r;
  assign out_ovf  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sum_r     <= '0;
      carry_r   <= '0;
      cnt       <= '0;
      out_sum   <= '0;
      out_count <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (accept) begin
          sum_r   <= operand;
          carry_r <= '0;
          cnt     <= CNT_W'(1);
        end
        ACCUM: if (accept) begin
          sum_r   <= csa_s;
          carry_r <= csa_c;
          cnt     <= cnt + 1'b1;
        end
        RESOLVE: begin
          out_sum   <= resolved[RES_W-1:0];
          out_count <= cnt;
        end
        default: ;
      endcase
    end
  end

`ifdef CSA_OVF_DETECT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_r   <= 1'b0;
      out_ovf <= 1'b0;
    end else begin
      case (state)
        IDLE:    if (accept) ovf_r <= 1'b0;
        ACCUM:   if (accept && csa_m[RES_W-1]) ovf_r <= 1'b1;
        RESOLVE: out_ovf <= ovf_r | resolved[RES_W];
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_csa_multi_operand_ctrl.sv
// Drives two controller instances (RES_W=8 and RES_W=6) with one shared operand stream and checks both against plain-integer sums.
module tb_csa_multi_operand_ctrl;

  localparam int WIDTH = 4;
  localparam int MAXN  = 16;
  localparam int CW    = $clog2(MAXN + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_last, out_ready;
  logic [WIDTH-1:0] in_data;
  logic             rdy8, rdy6, vld8, vld6, ovf8, ovf6;
  logic [7:0]       sum8;
  logic [5:0]       sum6;
  logic [CW-1:0]    cnt8, cnt6;

  int checks = 0;
  int errors = 0;
  int ops_q[$];

  always #5 clk = ~clk;

  csa_multi_operand_ctrl #(.WIDTH(WIDTH), .RES_W(8), .MAX_OPS(MAXN)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy8), .in_data(in_data),
    .in_last(in_last), .out_valid(vld8), .out_ready(out_ready), .out_sum(sum8),
    .out_count(cnt8), .out_ovf(ovf8));

  csa_multi_operand_ctrl #(.WIDTH(WIDTH), .RES_W(6), .MAX_OPS(MAXN)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy6), .in_data(in_data),
    .in_last(in_last), .out_valid(vld6), .out_ready(out_ready), .out_sum(sum6),
    .out_count(cnt6), .out_ovf(ovf6));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_result(input string tag, input int total, input int n);
    int eo8, eo6;
`ifdef CSA_OVF_DETECT_EN
    eo8 = (total > 255) ? 1 : 0;
    eo6 = (total > 63) ? 1 : 0;
`else
    eo8 = 0;
    eo6 = 0;
`endif
    check({tag, " out_valid8"}, 32'(vld8), 1);
    check({tag, " out_valid6"}, 32'(vld6), 1);
    check({tag, " in_ready8"}, 32'(rdy8), 0);
    check({tag, " in_ready6"}, 32'(rdy6), 0);
    check({tag, " sum8"}, 32'(sum8), total % 256);
    check({tag, " sum6"}, 32'(sum6), total % 64);
    check({tag, " count8"}, 32'(cnt8), n);
    check({tag, " count6"}, 32'(cnt6), n);
    check({tag, " ovf8"}, 32'(ovf8), eo8);
    check({tag, " ovf6"}, 32'(ovf6), eo6);
  endtask

  // Sends ops_q; the group ends on in_last or after MAXN operands, whichever comes first.
  task automatic run_group(input string tag, input bit use_last, input int stall, input int gap_max);
    int total, n, g;
    total = 0;
    n = 0;
    out_ready = (stall == 0);
    foreach (ops_q[i]) begin
      g = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
      repeat (g) begin
        in_valid = 1'b0;
        in_data  = WIDTH'($urandom);
        in_last  = 1'($urandom);
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = WIDTH'(ops_q[i]);
      in_last  = use_last && (i == ops_q.size() - 1);
      check({tag, " in_ready before accept"}, 32'(rdy8 & rdy6), 1);
      @(negedge clk);
      total += ops_q[i];
      n++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check({tag, " resolve out_valid"}, 32'(vld8 | vld6), 0);
    check({tag, " resolve in_ready"}, 32'(rdy8 | rdy6), 0);
    @(negedge clk);
    check_result(tag, total, n);
    repeat (stall) begin
      @(negedge clk);
      check_result({tag, " hold"}, total, n);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check({tag, " after handshake out_valid"}, 32'(vld8 | vld6), 0);
    check({tag, " after handshake in_ready"}, 32'(rdy8 & rdy6), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    bit ul;
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b1;
    #1;
    check("reset in_ready", 32'(rdy8 | rdy6), 0);
    check("reset out_valid", 32'(vld8 | vld6), 0);
    check("reset sum", 32'(sum8) | 32'(sum6), 0);
    check("reset count", 32'(cnt8) | 32'(cnt6), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle in_ready", 32'(rdy8 & rdy6), 1);

    ops_q = '{5, 3, 6};      run_group("g536", 1, 0, 0);
    ops_q = '{2, 12, 10};    run_group("g21210", 1, 0, 0);
    ops_q = '{9};            run_group("single", 1, 0, 0);
    ops_q = {};
    repeat (16) ops_q.push_back(15);
    run_group("auto16", 0, 0, 0);
    ops_q = '{15, 15, 15, 15, 15}; run_group("ovf75", 1, 0, 0);
    ops_q = '{4, 8, 1};      run_group("stall", 1, 3, 0);
    ops_q = '{1, 1};         run_group("g11", 1, 0, 0);
    ops_q = {};
    repeat (16) ops_q.push_back(15);
    run_group("last_at_max", 1, 0, 0);

    // Abort a group midway with reset, then confirm no stale contribution.
    in_valid = 1'b1; in_data = 4'd3; in_last = 1'b0;
    @(negedge clk);
    in_data = 4'd4;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midreset out_valid", 32'(vld8 | vld6), 0);
    check("midreset in_ready", 32'(rdy8 | rdy6), 0);
    check("midreset sum", 32'(sum8) | 32'(sum6), 0);
    check("midreset count", 32'(cnt8) | 32'(cnt6), 0);
    check("midreset ovf", 32'(ovf8 | ovf6), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    ops_q = '{7, 7};         run_group("post_reset", 1, 0, 0);

    for (int k = 0; k < 25; k++) begin
      n = $urandom_range(1, MAXN);
      ul = (n < MAXN) ? 1'b1 : 1'($urandom);
      ops_q = {};
      for (int j = 0; j < n; j++) ops_q.push_back($urandom_range(0, 15));
      run_group($sformatf("rand%0d", k), ul, $urandom_range(0, 3), 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
